// File: rtl/uart_rx_oversample.sv
// rtl/uart_rx_oversample.sv - oversampled 8-N-1 UART receiver, mid-bit sampling
// Define UART_RX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_rx_oversample #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_serial,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 rx_busy,
    output logic                 frame_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]    IDX_LAST = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           sync_q, sync_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_done_q, rx_done_d;
    logic                 rx_busy_q, rx_busy_d;
    logic                 frame_err_q, frame_err_d;
    logic                 rxs;
`ifdef UART_RX_PARITY_EN
    logic                 par_q, par_d;
    logic                 parity_err_q, parity_err_d;
`endif

    // Only the second synchroniser stage may steer the FSM.
    assign rxs = sync_q[1];

    always_comb begin
        state_d     = state_q;
        sync_d      = {sync_q[0], rx_serial};
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shreg_d     = shreg_q;
        rx_data_d   = rx_data_q;
        rx_done_d   = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d        = par_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!rxs) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == CNT_MID) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rxs ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shreg_d = {rxs, shreg_q[DATA_BITS-1:1]};
                    if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    par_d   = rxs;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`endif
            STOP: begin
                // Leaving at mid-stop lets a following start edge be caught with no idle gap.
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rxs) begin
                        rx_data_d = shreg_q;
                        rx_done_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                        parity_err_d = ^{shreg_q, par_q};
`endif
                        state_d   = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT_HIGH: begin
                if (rxs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        rx_busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sync_q      <= 2'b11;
            cnt_q       <= '0;
            idx_q       <= '0;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            rx_done_q   <= 1'b0;
            rx_busy_q   <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rx_done_q   <= rx_done_d;
            rx_busy_q   <= rx_busy_d;
            frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_done   = rx_done_q;
    assign rx_busy   = rx_busy_q;
    assign frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule
